// File: rtl/memoredf_pkg.sv
// memoredf_pkg
// Shared types, default parameter values and width helpers for the MemorEDF
// datapath blocks.
//   DEFAULT_*   : default parameter values for the datapath modules
//   safe_clog2  : ceil(log2(n)), never less than 1, so an index or id field
//                 never collapses to zero width
//   queue_id_t  : destination queue id for the default queue count
package memoredf_pkg;

    localparam int DEFAULT_DATA_SIZE        = 512;
    localparam int DEFAULT_NUMBER_OF_QUEUES = 4;
    localparam int DEFAULT_NUMBER_OF_INPUTS = 4;

    function automatic int safe_clog2(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

    typedef logic [$clog2(DEFAULT_NUMBER_OF_QUEUES)-1:0] queue_id_t;

endpackage

// File: rtl/decoupled_skid_buffer.sv
// decoupled_skid_buffer
// Two-entry registered skid stage. The main entry drives the output; the skid
// entry catches the single word that can be accepted in the cycle the output
// stalls. in_ready comes from a flop only, so no ready path runs from
// out_ready back to in_ready.
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready   : upstream handshake (in_ready = skid entry empty)
//   in_data   [WIDTH]     : upstream payload
//   out_valid / out_ready : downstream handshake (out_valid registered)
//   out_data  [WIDTH]     : registered payload, held steady while stalled
module decoupled_skid_buffer
    import memoredf_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_fire;
    logic             out_fire;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        in_fire      = in_valid && !skid_valid_q;
        out_fire     = main_valid_q && out_ready;

        if (out_fire) begin
            if (skid_valid_q) begin
                // in_fire cannot be set here: a full skid entry blocks input.
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            if (main_valid_q) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end else begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/decoupled_io_arbiter.sv
// decoupled_io_arbiter
// Merges NUMBER_OF_INPUTS valid/ready packet streams into one registered
// output stream. A combinational arbiter picks one valid input per cycle and
// the winner's {id, packet, source} is captured by decoupled_skid_buffer.
// Build option:
//   DECOUPLED_IO_ARBITER_ROUND_ROBIN_EN defined   : round-robin arbitration
//       searching upward from rr_ptr, which moves past each granted input
//   DECOUPLED_IO_ARBITER_ROUND_ROBIN_EN undefined : fixed priority, lowest
//       valid index wins, no pointer register
// Ports:
//   clock, reset          : rising-edge clock, asynchronous active-high reset
//   packetizers_valid [N] : per-input valid
//   packetizers_ready [N] : per-input ready, one-hot or zero
//   packetizers_id    [N][IDW], packetizers_packet [N][DATA_SIZE] : payloads
//   queues_valid / queues_ready : output handshake (queues_valid registered)
//   queues_id, queues_packet, queues_source : registered output fields
module decoupled_io_arbiter
    import memoredf_pkg::*;
#(
    parameter int DATA_SIZE        = DEFAULT_DATA_SIZE,
    parameter int NUMBER_OF_QUEUES = DEFAULT_NUMBER_OF_QUEUES,
    parameter int NUMBER_OF_INPUTS = DEFAULT_NUMBER_OF_INPUTS
) (
    input  logic                                                          clock,
    input  logic                                                          reset,
    input  logic [NUMBER_OF_INPUTS-1:0]                                   packetizers_valid,
    output logic [NUMBER_OF_INPUTS-1:0]                                   packetizers_ready,
    input  logic [NUMBER_OF_INPUTS-1:0][safe_clog2(NUMBER_OF_QUEUES)-1:0] packetizers_id,
    input  logic [NUMBER_OF_INPUTS-1:0][DATA_SIZE-1:0]                    packetizers_packet,
    output logic                                                          queues_valid,
    input  logic                                                          queues_ready,
    output logic [safe_clog2(NUMBER_OF_QUEUES)-1:0]                       queues_id,
    output logic [DATA_SIZE-1:0]                                          queues_packet,
    output logic [safe_clog2(NUMBER_OF_INPUTS)-1:0]                       queues_source
);

    localparam int IW    = safe_clog2(NUMBER_OF_INPUTS);
    localparam int IDW   = safe_clog2(NUMBER_OF_QUEUES);
    localparam int WIDTH = IDW + DATA_SIZE + IW;

    logic [IW-1:0]    rr_base;
    logic [IW-1:0]    grant;
    logic             any_valid;
    logic             accept_ready;
    logic             in_transfer;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_data;
    int               idx;

`ifdef DECOUPLED_IO_ARBITER_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (in_transfer) begin
            rr_ptr_d = (grant == IW'(NUMBER_OF_INPUTS - 1)) ? '0 : grant + IW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_base = rr_ptr_q;
`else
    assign rr_base = '0;
`endif

    // First valid input at or above rr_base, wrapping modulo the input count.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUMBER_OF_INPUTS; k++) begin
            idx = (int'(rr_base) + k) % NUMBER_OF_INPUTS;
            if (!any_valid && packetizers_valid[idx]) begin
                any_valid = 1'b1;
                grant     = IW'(idx);
            end
        end
    end

    // Ready only ever sees valid and flops, never queues_ready.
    always_comb begin
        packetizers_ready = '0;
        if (any_valid && accept_ready) begin
            packetizers_ready[grant] = 1'b1;
        end
    end

    assign in_transfer = any_valid && accept_ready;
    assign in_data     = {packetizers_id[grant], packetizers_packet[grant], grant};

    decoupled_skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (any_valid),
        .in_ready  (accept_ready),
        .in_data   (in_data),
        .out_valid (queues_valid),
        .out_ready (queues_ready),
        .out_data  (out_data)
    );

    assign {queues_id, queues_packet, queues_source} = out_data;

endmodule

// File: tb/tb_decoupled_io_arbiter.sv
module tb_decoupled_io_arbiter;

    localparam int DS = 32;

    logic             clock;
    logic             reset;
    logic [3:0]       packetizers_valid;
    logic [3:0]       packetizers_ready;
    logic [3:0][1:0]  packetizers_id;
    logic [3:0][DS-1:0] packetizers_packet;
    logic             queues_valid;
    logic             queues_ready;
    logic [1:0]       queues_id;
    logic [DS-1:0]    queues_packet;
    logic [1:0]       queues_source;

    int checks;
    int failures;

    decoupled_io_arbiter #(
        .DATA_SIZE        (DS),
        .NUMBER_OF_QUEUES (4),
        .NUMBER_OF_INPUTS (4)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .packetizers_valid  (packetizers_valid),
        .packetizers_ready  (packetizers_ready),
        .packetizers_id     (packetizers_id),
        .packetizers_packet (packetizers_packet),
        .queues_valid       (queues_valid),
        .queues_ready       (queues_ready),
        .queues_id          (queues_id),
        .queues_packet      (queues_packet),
        .queues_source      (queues_source)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clock);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        packetizers_valid  = '0;
        packetizers_id     = '0;
        packetizers_packet = '0;
        queues_ready       = 1'b1;
        #3;
        checks++;
        if (queues_valid !== 1'b0 || queues_id !== 2'd0 || queues_packet !== '0 || queues_source !== 2'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b id=%0d pkt=%h src=%0d, want all zero",
                     queues_valid, queues_id, queues_packet, queues_source);
        end
        checks++;
        if (packetizers_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready_idle: got %b want 0000", packetizers_ready);
        end
        reset = 1'b0;
        packetizers_valid = 4'b0001;
        #1;
        checks++;
        if (packetizers_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_ready_in0: got %b want 0001", packetizers_ready);
        end
        packetizers_valid = '0;
        step();
    endtask

    task automatic test_single_input();
        queues_ready          = 1'b1;
        packetizers_valid     = 4'b0100;
        packetizers_id[2]     = 2'd3;
        packetizers_packet[2] = 32'h0000_00A5;
        @(negedge clock);
        checks++;
        if (packetizers_ready !== 4'b0100) begin
            failures++;
            $display("FAIL single_ready: got %b want 0100", packetizers_ready);
        end
        step();
        packetizers_valid = '0;
        checks++;
        if (queues_valid !== 1'b1 || queues_id !== 2'd3 || queues_packet !== 32'h0000_00A5 || queues_source !== 2'd2) begin
            failures++;
            $display("FAIL single_output: got v=%b id=%0d pkt=%h src=%0d, want v=1 id=3 pkt=000000a5 src=2",
                     queues_valid, queues_id, queues_packet, queues_source);
        end
    endtask

    // Runs straight after test_single_input, so with round-robin the pointer sits at 3.
    task automatic test_wrap();
        logic [3:0] first_ready;
        logic [3:0] second_ready;
        logic [1:0] first_src;
        logic [1:0] second_src;
`ifdef DECOUPLED_IO_ARBITER_ROUND_ROBIN_EN
        first_ready = 4'b1000; first_src = 2'd3;
        second_ready = 4'b0010; second_src = 2'd1;
`else
        first_ready = 4'b0010; first_src = 2'd1;
        second_ready = 4'b1000; second_src = 2'd3;
`endif
        queues_ready          = 1'b1;
        packetizers_id[1]     = 2'd1;
        packetizers_packet[1] = 32'h1111_0001;
        packetizers_id[3]     = 2'd2;
        packetizers_packet[3] = 32'h3333_0003;
        packetizers_valid     = 4'b1010;
        @(negedge clock);
        checks++;
        if (packetizers_ready !== first_ready) begin
            failures++;
            $display("FAIL wrap_first_ready: got %b want %b", packetizers_ready, first_ready);
        end
        step();
        packetizers_valid = second_ready;
        checks++;
        if (queues_valid !== 1'b1 || queues_source !== first_src) begin
            failures++;
            $display("FAIL wrap_first_src: got v=%b src=%0d want v=1 src=%0d", queues_valid, queues_source, first_src);
        end
        @(negedge clock);
        checks++;
        if (packetizers_ready !== second_ready) begin
            failures++;
            $display("FAIL wrap_second_ready: got %b want %b", packetizers_ready, second_ready);
        end
        step();
        packetizers_valid = '0;
        checks++;
        if (queues_valid !== 1'b1 || queues_source !== second_src) begin
            failures++;
            $display("FAIL wrap_second_src: got v=%b src=%0d want v=1 src=%0d", queues_valid, queues_source, second_src);
        end
        step();
        checks++;
        if (queues_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_drain: got v=%b want 0", queues_valid);
        end
    endtask

    task automatic test_fairness();
        int seq [4];
        logic [1:0] exp_src;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            seq[i] = 0;
            packetizers_id[i]     = 2'(i);
            packetizers_packet[i] = 32'(i * 256);
        end
        queues_ready      = 1'b1;
        packetizers_valid = 4'b1111;
        for (int j = 0; j < 8; j++) begin
`ifdef DECOUPLED_IO_ARBITER_ROUND_ROBIN_EN
            exp_src = 2'(j % 4);
`else
            exp_src = 2'd0;
`endif
            @(negedge clock);
            checks++;
            if (packetizers_ready !== (4'b0001 << exp_src)) begin
                failures++;
                $display("FAIL fair_ready[%0d]: got %b want %b", j, packetizers_ready, 4'b0001 << exp_src);
            end
            step();
            checks++;
            if (queues_valid !== 1'b1 || queues_source !== exp_src ||
                queues_packet !== 32'(int'(exp_src) * 256 + seq[exp_src])) begin
                failures++;
                $display("FAIL fair_out[%0d]: got v=%b src=%0d pkt=%h want v=1 src=%0d pkt=%h", j,
                         queues_valid, queues_source, queues_packet, exp_src,
                         32'(int'(exp_src) * 256 + seq[exp_src]));
            end
            seq[exp_src]++;
            packetizers_packet[exp_src] = 32'(int'(exp_src) * 256 + seq[exp_src]);
        end
        packetizers_valid = '0;
        step();
    endtask

    task automatic test_back_pressure();
        logic [DS-1:0] exp_pkt [8];
        logic [1:0]    exp_id  [8];
        int sent;
        int recv;
        logic [DS-1:0] held_pkt;
        logic [1:0]    held_id;
        logic          in_hs;
        logic          out_hs;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            exp_pkt[k] = 32'h0000_0100 + 32'(k);
            exp_id[k]  = 2'(k % 4);
        end
        sent = 0;
        recv = 0;
        held_pkt = '0;
        held_id  = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            queues_ready          = !(cyc >= 3 && cyc <= 5);
            packetizers_valid     = (sent < 8) ? 4'b0001 : 4'b0000;
            packetizers_packet[0] = exp_pkt[sent % 8];
            packetizers_id[0]     = exp_id[sent % 8];
            @(negedge clock);
            if (cyc == 3) begin
                held_pkt = queues_packet;
                held_id  = queues_id;
            end
            if (cyc == 4 || cyc == 5) begin
                checks++;
                if (queues_valid !== 1'b1 || queues_packet !== held_pkt || queues_id !== held_id) begin
                    failures++;
                    $display("FAIL stall_stable[%0d]: got v=%b id=%0d pkt=%h want v=1 id=%0d pkt=%h",
                             cyc, queues_valid, queues_id, queues_packet, held_id, held_pkt);
                end
            end
            if (cyc == 5) begin
                checks++;
                if (packetizers_ready !== 4'b0000 || (sent - recv) != 2) begin
                    failures++;
                    $display("FAIL bp_buffered: got ready=%b buffered=%0d want ready=0000 buffered=2",
                             packetizers_ready, sent - recv);
                end
            end
            if (cyc == 6) begin
                checks++;
                if (packetizers_ready !== 4'b0000) begin
                    failures++;
                    $display("FAIL bp_release_lag: got %b want 0000", packetizers_ready);
                end
            end
            if (cyc == 7) begin
                checks++;
                if (packetizers_ready !== 4'b0001) begin
                    failures++;
                    $display("FAIL bp_ready_return: got %b want 0001", packetizers_ready);
                end
            end
            in_hs  = packetizers_valid[0] && packetizers_ready[0];
            out_hs = queues_valid && queues_ready;
            if (out_hs) begin
                checks++;
                if (recv >= 8 || queues_packet !== exp_pkt[recv % 8] || queues_id !== exp_id[recv % 8]) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: got id=%0d pkt=%h want id=%0d pkt=%h", recv,
                             queues_id, queues_packet, exp_id[recv % 8], exp_pkt[recv % 8]);
                end
                recv++;
            end
            if (in_hs) sent++;
            @(posedge clock);
            #1;
            if (recv >= 8 && sent >= 8) break;
        end
        checks++;
        if (recv != 8 || sent != 8) begin
            failures++;
            $display("FAIL bp_count: got sent=%0d recv=%0d want 8/8", sent, recv);
        end
        packetizers_valid = '0;
        queues_ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_stream();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            packetizers_id[i]     = 2'(3 - i);
            packetizers_packet[i] = 32'hCAFE_0000 + 32'(i);
        end
        queues_ready      = 1'b0;
        packetizers_valid = 4'b1111;
        step();
        step();
        @(negedge clock);
        checks++;
        if (queues_valid !== 1'b1 || packetizers_ready !== 4'b0000) begin
            failures++;
            $display("FAIL mid_full: got v=%b ready=%b want v=1 ready=0000", queues_valid, packetizers_ready);
        end
        step();
        #1 reset = 1'b1;
        #1;
        checks++;
        if (queues_valid !== 1'b0 || queues_source !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset_async: got v=%b src=%0d want v=0 src=0", queues_valid, queues_source);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (queues_valid !== 1'b0 || queues_source !== 2'd0 || packetizers_ready !== 4'b0001) begin
            failures++;
            $display("FAIL mid_reset_after: got v=%b src=%0d ready=%b want v=0 src=0 ready=0001",
                     queues_valid, queues_source, packetizers_ready);
        end
        packetizers_valid = '0;
        queues_ready = 1'b1;
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        queues_ready = 1'b1;
        packetizers_valid  = '0;
        packetizers_id     = '0;
        packetizers_packet = '0;
        test_reset();
        test_single_input();
        test_wrap();
        test_fairness();
        test_back_pressure();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
